bounce_generator: RTL and testbench
===================================

BOUNCE_GENERATOR -- requirements
Module: bounce_generator

Interface
REQ-001 The block SHALL have parameter MAX_BOUNCES, default 16: upper bound on toggles per transition (1..255).
REQ-002 The block SHALL have parameter MAX_GAP_TICKS, default 16: upper bound on cycles between toggles (1..255).
REQ-003 The block SHALL have parameter SETTLE_TICKS, default 100: cycles the target level is held before done.
REQ-004 The block SHALL have parameter RANDOM, default 1: 1 selects LFSR-derived bounce and gap values; 0 selects fixed maxima.
REQ-005 The block SHALL have parameter SEED, default 16'hACE1: the LFSR reset value.
REQ-006 The block SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst  input  1  reset, asynchronous assert, active-low, released synchronously to clk by the integrator.
REQ-008 The block SHALL have port start  input  1  single-cycle request to begin a transition.
REQ-009 The block SHALL have port target_level  input  1  level bouncy_out settles to; sampled when start is accepted.
REQ-010 The block SHALL have port bouncy_out  output  1  emulated mechanical contact, registered.
REQ-011 The block SHALL have port busy  output  1  high from the cycle after acceptance until done.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse at end of settle.
REQ-013 The block SHALL have port bounce_count  output  8  toggles remaining in the current BOUNCE phase.

Function
REQ-014 The block SHALL implement the FSM states IDLE, BOUNCE and SETTLE, each with registered outputs.
REQ-015 The LFSR SHALL be a 16-bit Galois LFSR with mask 16'hB400 that advances every cycle out of reset; if SEED is 0, the value 16'h0001 SHALL be used instead.
REQ-016 A start in IDLE SHALL be accepted, latching target_level into tgt.
- If tgt equals bouncy_out: go to SETTLE with no toggles.
- Otherwise: go to BOUNCE.
REQ-017 In BOUNCE entry, the toggle count N SHALL be loaded.
- RANDOM=1: N = (lfsr[7:0] mod MAX_BOUNCES) + 1.
- RANDOM=0: N = MAX_BOUNCES.
REQ-018 The gap G SHALL be reloaded before each toggle.
- RANDOM=1: G = (lfsr[15:8] mod MAX_GAP_TICKS) + 1.
- RANDOM=0: G = MAX_GAP_TICKS.
REQ-019 In BOUNCE, bouncy_out SHALL invert exactly once per G elapsed cycles, and bounce_count SHALL decrement on each inversion.
REQ-020 The first inversion SHALL occur G cycles after entry, and the final inversion SHALL drive bouncy_out to tgt, overriding toggle parity.
REQ-021 When bounce_count reaches 0, the FSM SHALL enter SETTLE with bouncy_out = tgt.
REQ-022 In SETTLE, bouncy_out SHALL be held at tgt for exactly SETTLE_TICKS cycles; done SHALL then pulse for 1 cycle, busy SHALL fall in the same cycle, and the FSM SHALL return to IDLE.
REQ-023 A start while busy=1 or while done=1 SHALL be ignored and SHALL NOT alter tgt, the counters or the LFSR sequence.
REQ-024 A start in the cycle after done SHALL be accepted normally (back-to-back transitions allowed).
REQ-025 All counters SHALL be 8-bit and saturating-safe, with no wrap-around.
REQ-026 The maximum transition length SHALL be MAX_BOUNCES*MAX_GAP_TICKS + SETTLE_TICKS + 2 cycles.

Reset
REQ-027 While rst=0, the block SHALL force state=IDLE, bouncy_out=0, busy=0, done=0, bounce_count=0 and lfsr=SEED (or 1).
REQ-028 A rst assertion mid-BOUNCE or mid-SETTLE SHALL abort immediately and asynchronously to the reset values, with no done pulse.
REQ-029 The first start after rst deasserts SHALL be accepted no earlier than the first rising clk edge with rst=1.

Verification
REQ-030 Test: RANDOM=0, MAX_BOUNCES=4, MAX_GAP_TICKS=3, SETTLE_TICKS=10; start with target 1 from 0 -> 4 inversions at +3, +6, +9, +12 cycles, bouncy_out=1 after the last, done 10 cycles later, busy low with done.
REQ-031 Test: start with target_level equal to bouncy_out -> zero inversions, done exactly SETTLE_TICKS cycles after acceptance.
REQ-032 Test: RANDOM=1, SEED=16'hACE1; 50 transitions alternating 1/0 -> N and G match a reference LFSR model; N in 1..MAX_BOUNCES; G in 1..MAX_GAP_TICKS; final level always = target.
REQ-033 Test: start pulses every cycle during BOUNCE -> trace identical to a single-start run.
REQ-034 Test: rst low mid-BOUNCE at toggle 2 -> bouncy_out=0, busy=0 asynchronously; no done; the next start behaves as from reset.
REQ-035 Test: chain the output into debouncer with BOUNCE_TICKS < SETTLE_TICKS -> debounced_out makes exactly one clean edge per transition.

Source files
------------

// File: rtl/bounce_generator.sv
// -----------------------------------------------------------------------------
// bounce_generator
//
// Emulates a bouncing mechanical contact. A start request makes bouncy_out
// chatter for a number of toggles with gaps between them, then hold the
// requested level for a settle period before a one-cycle done pulse.
// Bounce counts and gaps come from a 16-bit Galois LFSR (RANDOM=1) or are
// fixed at their maxima (RANDOM=0).
//
// Parameters
//   MAX_BOUNCES   upper bound on toggles per transition (1..255)
//   MAX_GAP_TICKS upper bound on cycles between toggles (1..255)
//   SETTLE_TICKS  cycles the target level is held before done
//   RANDOM        1: LFSR-derived bounce/gap values, 0: fixed maxima
//   SEED          LFSR reset value (0 is replaced by 16'h0001)
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous active-low reset
//   start         single-cycle transition request
//   target_level  level to settle to, sampled when start is accepted
//   bouncy_out    emulated contact output (registered)
//   busy          high from the cycle after acceptance until done
//   done          one-cycle pulse at the end of settle
//   bounce_count  toggles remaining in the current bounce phase
// -----------------------------------------------------------------------------
module bounce_generator #(
    parameter int          MAX_BOUNCES   = 16,
    parameter int          MAX_GAP_TICKS = 16,
    parameter int          SETTLE_TICKS  = 100,
    parameter int          RANDOM        = 1,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       target_level,
    output logic       bouncy_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] bounce_count
);

    // An all-zero Galois LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    localparam logic [7:0] MAX_B8  = 8'(MAX_BOUNCES);
    localparam logic [7:0] MAX_G8  = 8'(MAX_GAP_TICKS);
    // Settle counter is 8 bits; out-of-range settle lengths are clamped
    // rather than allowed to wrap.
    localparam logic [7:0] SETTLE8 = (SETTLE_TICKS > 255) ? 8'd255 :
                                     (SETTLE_TICKS < 1)   ? 8'd1   :
                                     8'(SETTLE_TICKS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t      state,       state_nx;
    logic [15:0] lfsr;
    logic        tgt,         tgt_nx;
    logic [7:0]  gap_cnt,     gap_nx;
    logic [7:0]  settle_cnt,  settle_nx;
    logic        bouncy_nx;
    logic        busy_nx;
    logic        done_nx;
    logic [7:0]  count_nx;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
    endfunction

    function automatic logic [7:0] pick_bounces(input logic [7:0] r);
        logic [7:0] n;
        if (RANDOM != 0) n = (r % MAX_B8) + 8'd1;
        else             n = MAX_B8;
        return n;
    endfunction

    function automatic logic [7:0] pick_gap(input logic [7:0] r);
        logic [7:0] g;
        if (RANDOM != 0) g = (r % MAX_G8) + 8'd1;
        else             g = MAX_G8;
        return g;
    endfunction

    // Next-state and next-output logic. Every output is a register, so this
    // block computes the values loaded on the next rising edge.
    always_comb begin
        state_nx  = state;
        tgt_nx    = tgt;
        gap_nx    = gap_cnt;
        settle_nx = settle_cnt;
        bouncy_nx = bouncy_out;
        busy_nx   = busy;
        done_nx   = 1'b0;
        count_nx  = bounce_count;

        case (state)
            IDLE: begin
                // While done is still high the request is ignored, so the
                // earliest new acceptance is the cycle after done.
                if (start && !done) begin
                    tgt_nx  = target_level;
                    busy_nx = 1'b1;
                    if (target_level == bouncy_out) begin
                        state_nx  = SETTLE;
                        settle_nx = SETTLE8;
                        count_nx  = 8'd0;
                    end else begin
                        state_nx = BOUNCE;
                        count_nx = pick_bounces(lfsr[7:0]);
                        gap_nx   = pick_gap(lfsr[15:8]);
                    end
                end
            end

            BOUNCE: begin
                if (gap_cnt > 8'd1) begin
                    gap_nx = gap_cnt - 8'd1;
                end else if (bounce_count <= 8'd1) begin
                    // Last toggle lands on the target regardless of parity.
                    bouncy_nx = tgt;
                    count_nx  = 8'd0;
                    state_nx  = SETTLE;
                    settle_nx = SETTLE8;
                end else begin
                    bouncy_nx = ~bouncy_out;
                    count_nx  = bounce_count - 8'd1;
                    gap_nx    = pick_gap(lfsr[15:8]);
                end
            end

            SETTLE: begin
                if (settle_cnt > 8'd1) begin
                    settle_nx = settle_cnt - 8'd1;
                end else begin
                    settle_nx = 8'd0;
                    state_nx  = IDLE;
                    busy_nx   = 1'b0;
                    done_nx   = 1'b1;
                end
            end

            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            lfsr         <= LFSR_INIT;
            tgt          <= 1'b0;
            gap_cnt      <= 8'd0;
            settle_cnt   <= 8'd0;
            bouncy_out   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            bounce_count <= 8'd0;
        end else begin
            state        <= state_nx;
            lfsr         <= lfsr_step(lfsr);
            tgt          <= tgt_nx;
            gap_cnt      <= gap_nx;
            settle_cnt   <= settle_nx;
            bouncy_out   <= bouncy_nx;
            busy         <= busy_nx;
            done         <= done_nx;
            bounce_count <= count_nx;
        end
    end

endmodule

// File: tb/tb_bounce_generator.sv
// -----------------------------------------------------------------------------
// tb_bounce_generator
//
// Two instances of bounce_generator: a fixed-timing one (RANDOM=0, 4 bounces,
// gap 3, settle 10) and an LFSR-driven one (RANDOM=1, SEED 16'hACE1).
// Expected traces are derived per transition from the toggle schedule:
// N and each gap come from the LFSR value present at the relevant edge,
// toggles happen at cumulative gap offsets, done follows the last toggle
// by the settle length. A behavioural debouncer watches the fixed instance.
// -----------------------------------------------------------------------------
module tb_bounce_generator;

    localparam int          F_MB = 4;
    localparam int          F_MG = 3;
    localparam int          F_S  = 10;
    localparam int          R_MB = 6;
    localparam int          R_MG = 9;
    localparam int          R_S  = 12;
    localparam logic [15:0] R_SEED   = 16'hACE1;
    localparam int          DB_TICKS = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       f_start = 1'b0, f_tgt = 1'b0;
    logic       f_bouncy, f_busy, f_done;
    logic [7:0] f_count;
    logic       r_start = 1'b0, r_tgt = 1'b0;
    logic       r_bouncy, r_busy, r_done;
    logic [7:0] r_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bounce_generator #(
        .MAX_BOUNCES(F_MB), .MAX_GAP_TICKS(F_MG), .SETTLE_TICKS(F_S),
        .RANDOM(0), .SEED(16'h1234)
    ) dut_fix (
        .clk(clk), .rst(rst), .start(f_start), .target_level(f_tgt),
        .bouncy_out(f_bouncy), .busy(f_busy), .done(f_done),
        .bounce_count(f_count)
    );

    bounce_generator #(
        .MAX_BOUNCES(R_MB), .MAX_GAP_TICKS(R_MG), .SETTLE_TICKS(R_S),
        .RANDOM(1), .SEED(R_SEED)
    ) dut_rnd (
        .clk(clk), .rst(rst), .start(r_start), .target_level(r_tgt),
        .bouncy_out(r_bouncy), .busy(r_busy), .done(r_done),
        .bounce_count(r_count)
    );

    // Reference LFSR: 16-bit Galois, mask 16'hB400, one step per clock.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int n);
        logic [15:0] x;
        x = v;
        for (int i = 0; i < n; i++) x = lfsr_next(x);
        return x;
    endfunction

    logic [15:0] mlfsr;
    always @(posedge clk or negedge rst) begin
        if (!rst) mlfsr <= R_SEED;
        else      mlfsr <= lfsr_next(mlfsr);
    end

    // Behavioural debouncer on the fixed instance output.
    logic db_out;
    int   db_cnt;
    int   db_edges;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_out   <= 1'b0;
            db_cnt   <= 0;
            db_edges <= 0;
        end else if (f_bouncy == db_out) begin
            db_cnt <= 0;
        end else if (db_cnt == DB_TICKS - 1) begin
            db_out   <= f_bouncy;
            db_cnt   <= 0;
            db_edges <= db_edges + 1;
        end else begin
            db_cnt <= db_cnt + 1;
        end
    end

    task automatic drive(input bit sel, input logic st, input logic tg);
        if (sel) begin r_start = st; r_tgt = tg; end
        else     begin f_start = st; f_tgt = tg; end
    endtask

    // Called and returns at a negedge. Requests a transition to tgt on the
    // selected instance and checks every cycle until one cycle after done.
    // With spam set, start is held high (random target) for the whole busy
    // period and during the done cycle.
    task automatic run_transition(input bit sel, input logic tgt, input bit spam,
                                  input string nm);
        logic        b0, ob, obusy, odone, pb;
        logic [7:0]  oc;
        logic [15:0] l;
        int          n, t, g, tdone, cnt, mb, mg, s, last_t;
        int          times[$];
        logic        eb;

        mb = sel ? R_MB : F_MB;
        mg = sel ? R_MG : F_MG;
        s  = sel ? R_S  : F_S;
        b0 = sel ? r_bouncy : f_bouncy;
        l  = mlfsr;
        drive(sel, 1'b1, tgt);

        times.delete();
        t = 0;
        if (tgt == b0) begin
            n = 0;
        end else begin
            n = sel ? (int'(l[7:0]) % R_MB) + 1 : F_MB;
            for (int k = 0; k < n; k++) begin
                g = sel ? (int'(l[15:8]) % R_MG) + 1 : F_MG;
                t = t + g;
                times.push_back(t);
                l = lfsr_adv(l, g);
            end
        end
        tdone  = t + s;
        pb     = b0;
        last_t = 0;

        for (int e = 0; e <= tdone + 1; e++) begin
            @(negedge clk);
            ob    = sel ? r_bouncy : f_bouncy;
            obusy = sel ? r_busy   : f_busy;
            odone = sel ? r_done   : f_done;
            oc    = sel ? r_count  : f_count;

            if (spam && e <= tdone) drive(sel, 1'b1, 1'($urandom_range(0, 1)));
            else                    drive(sel, 1'b0, 1'b0);

            cnt = 0;
            foreach (times[k]) if (times[k] <= e) cnt++;
            eb = (n > 0 && cnt == n) ? tgt : (b0 ^ cnt[0]);

            tests++;
            if (ob !== eb) begin
                fails++;
                $display("FAIL %s bouncy_out cycle %0d: got %b expected %b", nm, e, ob, eb);
            end
            tests++;
            if (obusy !== (e < tdone)) begin
                fails++;
                $display("FAIL %s busy cycle %0d: got %b expected %b", nm, e, obusy, (e < tdone));
            end
            tests++;
            if (odone !== (e == tdone)) begin
                fails++;
                $display("FAIL %s done cycle %0d: got %b expected %b", nm, e, odone, (e == tdone));
            end
            tests++;
            if (oc !== 8'(n - cnt)) begin
                fails++;
                $display("FAIL %s bounce_count cycle %0d: got %0d expected %0d", nm, e, oc, n - cnt);
            end
            if (e == 0 && n > 0) begin
                tests++;
                if (oc < 8'd1 || int'(oc) > mb) begin
                    fails++;
                    $display("FAIL %s N range: got %0d expected 1..%0d", nm, oc, mb);
                end
            end
            if (ob !== pb && e <= t) begin
                tests++;
                if (e - last_t < 1 || e - last_t > mg) begin
                    fails++;
                    $display("FAIL %s gap range cycle %0d: got %0d expected 1..%0d", nm, e, e - last_t, mg);
                end
                last_t = e;
            end
            pb = ob;
        end
    endtask

    task automatic test_reset;
        f_start = 1'b1;
        f_tgt   = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({f_bouncy, f_busy, f_done, f_count} !== 11'd0) begin
            fails++;
            $display("FAIL reset fixed outputs: got %b expected all zero", {f_bouncy, f_busy, f_done, f_count});
        end
        tests++;
        if ({r_bouncy, r_busy, r_done, r_count} !== 11'd0) begin
            fails++;
            $display("FAIL reset random outputs: got %b expected all zero", {r_bouncy, r_busy, r_done, r_count});
        end
        f_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fixed_sequence;
        run_transition(1'b0, 1'b1, 1'b0, "fixed_rise");
        run_transition(1'b0, 1'b0, 1'b0, "fixed_fall");
    endtask

    task automatic test_same_level;
        run_transition(1'b0, f_bouncy, 1'b0, "fixed_same");
        run_transition(1'b1, r_bouncy, 1'b0, "rand_same");
    endtask

    task automatic test_back_to_back;
        run_transition(1'b1, 1'b1, 1'b0, "b2b_rise");
        run_transition(1'b1, 1'b0, 1'b0, "b2b_fall");
        run_transition(1'b0, 1'b1, 1'b0, "b2b_fix_rise");
        run_transition(1'b0, 1'b0, 1'b0, "b2b_fix_fall");
    endtask

    task automatic test_start_spam;
        run_transition(1'b0, 1'b1, 1'b1, "spam_fixed");
        run_transition(1'b1, ~r_bouncy, 1'b1, "spam_rand");
    endtask

    task automatic hold_reset_check(input string nm);
        repeat (3) begin
            @(negedge clk);
            tests++;
            if (f_done !== 1'b0 || f_busy !== 1'b0) begin
                fails++;
                $display("FAIL %s held reset: got done=%b busy=%b expected 0 0", nm, f_done, f_busy);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_abort;
        if (f_bouncy !== 1'b1) run_transition(1'b0, 1'b1, 1'b0, "abort_prep");
        // Bounce toward 0; after the second toggle the output is back at 1.
        f_start = 1'b1;
        f_tgt   = 1'b0;
        for (int e = 0; e <= 2 * F_MG; e++) begin
            @(negedge clk);
            f_start = 1'b0;
        end
        tests++;
        if (f_busy !== 1'b1 || f_bouncy !== 1'b1 || f_count !== 8'(F_MB - 2)) begin
            fails++;
            $display("FAIL abort_bounce pre: got busy=%b out=%b cnt=%0d expected 1 1 %0d",
                     f_busy, f_bouncy, f_count, F_MB - 2);
        end
        #2 rst = 1'b0;
        #1;
        tests++;
        if ({f_bouncy, f_busy, f_done, f_count} !== 11'd0) begin
            fails++;
            $display("FAIL abort_bounce async: got %b expected all zero", {f_bouncy, f_busy, f_done, f_count});
        end
        hold_reset_check("abort_bounce");
        run_transition(1'b0, 1'b1, 1'b0, "after_abort");

        // Same-level request goes straight to settle; abort partway.
        f_start = 1'b1;
        f_tgt   = 1'b1;
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            f_start = 1'b0;
        end
        tests++;
        if (f_busy !== 1'b1 || f_bouncy !== 1'b1) begin
            fails++;
            $display("FAIL abort_settle pre: got busy=%b out=%b expected 1 1", f_busy, f_bouncy);
        end
        #2 rst = 1'b0;
        #1;
        tests++;
        if (f_bouncy !== 1'b0 || f_busy !== 1'b0 || f_done !== 1'b0) begin
            fails++;
            $display("FAIL abort_settle async: got out=%b busy=%b done=%b expected 0 0 0",
                     f_bouncy, f_busy, f_done);
        end
        hold_reset_check("abort_settle");
    endtask

    task automatic test_debounce;
        int   e0;
        logic tg;
        for (int i = 0; i < 2; i++) begin
            e0 = db_edges;
            tg = ~f_bouncy;
            run_transition(1'b0, tg, 1'b0, "debounce");
            tests++;
            if (db_edges - e0 != 1 || db_out !== tg) begin
                fails++;
                $display("FAIL debounce edges: got %0d edges level %b expected 1 edge level %b",
                         db_edges - e0, db_out, tg);
            end
        end
    endtask

    task automatic test_random_transitions;
        for (int i = 0; i < 50; i++) begin
            run_transition(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, (i % 7 == 3), "random");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_fixed_sequence();
        test_same_level();
        test_back_to_back();
        test_start_spam();
        test_abort();
        test_debounce();
        test_random_transitions();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
